// File: rtl/bfly_pkg.sv
// Shared definitions for the butterfly router node: flit field offsets,
// port index constants and the routing-bit helper.
package bfly_pkg;

  localparam int PORT0      = 0;
  localparam int PORT1      = 1;
  localparam int DEST_LSB   = 0;
  localparam int MAX_ADDR_W = 32;

  // The source field sits directly above the destination field.
  function automatic int src_lsb(input int addr_w);
    return addr_w;
  endfunction

  // Output selected by one destination bit; an out-of-range level routes to output 0.
  function automatic logic route_bit(input logic [MAX_ADDR_W-1:0] dest,
                                     input int unsigned          level,
                                     input int unsigned          addr_w);
    if (level >= addr_w) return 1'b0;
    return dest[level[4:0]];
  endfunction

endpackage

// File: rtl/bfly_router_node_if.sv
// Valid/ready flit link between butterfly nodes.
interface bfly_link_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/bfly_router_node_fifo.sv
// Per-port input FIFO: power-of-two depth, wrapping pointers, explicit
// occupancy counter and a combinational head read.
module bfly_fifo
  import bfly_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_q, wr_d;
  logic [PTR_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push_ok;
  logic              pop_ok;

  // Qualify requests and compute next pointers and occupancy; a full FIFO
  // refuses a write even when it is popped in the same cycle.
  always_comb begin
    full    = (cnt_q == CNT_W'(DEPTH));
    empty   = (cnt_q == '0);
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    wr_d    = wr_q + PTR_W'(push_ok);
    rd_d    = rd_q + PTR_W'(pop_ok);
    cnt_d   = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Flit storage; contents are meaningless until counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= din;
  end

  assign dout  = mem[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/bfly_router_node.sv
// 2x2 butterfly switching node: two input FIFOs, per-head route decode on
// one destination bit, a round-robin arbiter per output and registered outputs.
module bfly_router_node
  import bfly_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int ADDR_W = 3,
  parameter  int DEPTH  = 8,
  parameter  int LVL_W  = $clog2(ADDR_W),
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] level,
  bfly_link_if.slave       in0,
  bfly_link_if.slave       in1,
  bfly_link_if.master      out0,
  bfly_link_if.master      out1,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic [DATA_W-1:0] head    [2];
  logic [1:0]        empty;
  logic [1:0]        full;
  logic [1:0]        pop;
  logic [1:0]        tgt;
  logic [1:0]        req     [2];
  logic [1:0]        out_rdy;
  logic [1:0]        gnt_vld;
  logic [1:0]        gnt_idx;
  logic [DATA_W-1:0] data_q  [2];
  logic [DATA_W-1:0] data_d  [2];
  logic [1:0]        vld_q, vld_d;
  logic [1:0]        rr_q, rr_d;

  bfly_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (in0.valid),
    .pop   (pop[PORT0]),
    .din   (in0.data),
    .dout  (head[PORT0]),
    .count (cnt0),
    .full  (full[PORT0]),
    .empty (empty[PORT0])
  );

  bfly_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (in1.valid),
    .pop   (pop[PORT1]),
    .din   (in1.data),
    .dout  (head[PORT1]),
    .count (cnt1),
    .full  (full[PORT1]),
    .empty (empty[PORT1])
  );

  assign in0.ready      = !full[PORT0];
  assign in1.ready      = !full[PORT1];
  assign out_rdy[PORT0] = out0.ready;
  assign out_rdy[PORT1] = out1.ready;

  // Route decode: each non-empty head requests exactly one output.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      tgt[i] = route_bit(MAX_ADDR_W'(head[i][DEST_LSB +: ADDR_W]), 32'(level), ADDR_W);
    end
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 2; i++) begin
        req[j][i] = !empty[i] && (tgt[i] == 1'(j));
      end
    end
  end

  // Round-robin arbiters and output-register next state; a head pops only
  // when the output it targets is free and grants it.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      gnt_vld[j] = 1'b0;
      gnt_idx[j] = 1'b0;
      data_d[j]  = data_q[j];
      vld_d[j]   = vld_q[j];
      rr_d[j]    = rr_q[j];
      if (!vld_q[j] || out_rdy[j]) begin
        if (req[j][0] && req[j][1]) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = rr_q[j];
        end else if (req[j][0]) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = 1'b0;
        end else if (req[j][1]) begin
          gnt_vld[j] = 1'b1;
          gnt_idx[j] = 1'b1;
        end
        vld_d[j] = gnt_vld[j];
        if (gnt_vld[j]) begin
          data_d[j] = head[gnt_idx[j]];
          rr_d[j]   = ~gnt_idx[j];
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      pop[i] = (gnt_vld[0] && (gnt_idx[0] == 1'(i))) ||
               (gnt_vld[1] && (gnt_idx[1] == 1'(i)));
    end
  end

  // Output registers and round-robin pointers; reset drops in-flight flits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      vld_q     <= '0;
      rr_q      <= '0;
    end else begin
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      vld_q     <= vld_d;
      rr_q      <= rr_d;
    end
  end

  assign out0.data  = data_q[PORT0];
  assign out0.valid = vld_q[PORT0];
  assign out1.data  = data_q[PORT1];
  assign out1.valid = vld_q[PORT1];

endmodule

// File: tb/tb_bfly_router_node.sv
// Directed bench for the butterfly router node.
module tb_bfly_router_node;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] level = 2'd0;
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  int         n_cmp = 0;
  int         n_bad = 0;

  bfly_link_if #(.DATA_W(64)) in0_if ();
  bfly_link_if #(.DATA_W(64)) in1_if ();
  bfly_link_if #(.DATA_W(64)) out0_if ();
  bfly_link_if #(.DATA_W(64)) out1_if ();

  bfly_router_node #(.DATA_W(64), .ADDR_W(3), .DEPTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .level (level),
    .in0   (in0_if),
    .in1   (in1_if),
    .out0  (out0_if),
    .out1  (out1_if),
    .cnt0  (cnt0),
    .cnt1  (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] lvl);
    in0_if.valid  = 1'b0;
    in1_if.valid  = 1'b0;
    in0_if.data   = '0;
    in1_if.data   = '0;
    out0_if.ready = 1'b1;
    out1_if.ready = 1'b1;
    rst   = 1'b0;
    level = lvl;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  function automatic logic [63:0] mk0(input int k);
    return 64'h0002 | (64'(k) << 16);
  endfunction
  function automatic logic [63:0] mk1(input int k);
    return 64'h1_0000_0002 | (64'(k) << 16);
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  k0, k1, oi, max0, o0seen;
    logic a0, a1, nr0;

    // Reset held with a valid input present
    in0_if.valid  = 1'b1;
    in0_if.data   = 64'h55;
    in1_if.valid  = 1'b0;
    in1_if.data   = '0;
    out0_if.ready = 1'b1;
    out1_if.ready = 1'b1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out0_valid", 64'(out0_if.valid), 64'd0);
    chk("rst_out1_valid", 64'(out1_if.valid), 64'd0);
    chk("rst_out0_data", out0_if.data, 64'd0);
    chk("rst_out1_data", out1_if.data, 64'd0);
    chk("rst_cnt0", 64'(cnt0), 64'd0);
    chk("rst_cnt1", 64'(cnt1), 64'd0);
    chk("rst_in0_ready", 64'(in0_if.ready), 64'd1);
    in0_if.valid = 1'b0;
    rst = 1'b1;
    step();
    chk("post_rst_ready", 64'(in0_if.ready), 64'd1);
    chk("post_rst_cnt0", 64'(cnt0), 64'd0);

    // Single flit, level 0, dest 101 -> out1
    do_reset(2'd0);
    in0_if.data  = 64'hABCD_0000_0000_0005;
    in0_if.valid = 1'b1;
    step();
    in0_if.valid = 1'b0;
    chk("single_cnt0", 64'(cnt0), 64'd1);
    chk("single_out1_early", 64'(out1_if.valid), 64'd0);
    step();
    chk("single_out1_valid", 64'(out1_if.valid), 64'd1);
    chk("single_out1_data", out1_if.data, 64'hABCD_0000_0000_0005);
    chk("single_out0_valid", 64'(out0_if.valid), 64'd0);
    step();
    chk("single_out1_clear", 64'(out1_if.valid), 64'd0);

    // Contention on out1, level 1, both inputs dest 010
    do_reset(2'd1);
    k0 = 0; k1 = 0; oi = 0; max0 = 0; o0seen = 0; nr0 = 1'b0;
    in0_if.data  = mk0(0);
    in1_if.data  = mk1(0);
    in0_if.valid = 1'b1;
    in1_if.valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      a0 = in0_if.valid && in0_if.ready;
      a1 = in1_if.valid && in1_if.ready;
      step();
      if (a0) begin k0++; in0_if.data = mk0(k0); end
      if (a1) begin k1++; in1_if.data = mk1(k1); end
      if (out1_if.valid) begin
        chk("cont_out1_data", out1_if.data, (oi % 2 == 0) ? mk0(oi / 2) : mk1(oi / 2));
        oi++;
      end
      if (out0_if.valid) o0seen++;
      if (int'(cnt0) > max0) max0 = int'(cnt0);
      if (!in0_if.ready) nr0 = 1'b1;
    end
    in0_if.valid = 1'b0;
    in1_if.valid = 1'b0;
    chk("cont_out1_count", 64'(oi), 64'd39);
    chk("cont_out0_unused", 64'(o0seen), 64'd0);
    chk("cont_cnt0_max", 64'(max0), 64'd8);
    chk("cont_ready0_drop", 64'(nr0), 64'd1);

    // Backpressure on out0 with 9 flits into in0
    do_reset(2'd0);
    out0_if.ready = 1'b0;
    k0 = 0;
    in0_if.data  = 64'hB000_0000_0000 | (64'(k0) << 8);
    in0_if.valid = 1'b1;
    for (int c = 0; c < 20 && k0 < 9; c++) begin
      a0 = in0_if.valid && in0_if.ready;
      step();
      if (a0) begin
        k0++;
        in0_if.data = 64'hB000_0000_0000 | (64'(k0) << 8);
      end
    end
    in0_if.valid = 1'b0;
    chk("bp_accepts", 64'(k0), 64'd9);
    chk("bp_cnt0_full", 64'(cnt0), 64'd8);
    chk("bp_ready0_low", 64'(in0_if.ready), 64'd0);
    chk("bp_out0_valid", 64'(out0_if.valid), 64'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_out0_hold", out0_if.data, 64'hB000_0000_0000);
      chk("bp_cnt0_hold", 64'(cnt0), 64'd8);
    end
    out0_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("bp_drain_valid", 64'(out0_if.valid), 64'd1);
      chk("bp_drain_data", out0_if.data, 64'hB000_0000_0000 | (64'(i) << 8));
    end
    step();
    chk("bp_drain_end", 64'(out0_if.valid), 64'd0);
    chk("bp_drain_cnt0", 64'(cnt0), 64'd0);

    // Parallel streams: in0 -> out0 (dest 000), in1 -> out1 (dest 001)
    do_reset(2'd0);
    in0_if.data  = 64'hC000_0000 | (64'(0) << 8);
    in1_if.data  = 64'hD000_0001 | (64'(0) << 8);
    in0_if.valid = 1'b1;
    in1_if.valid = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e < 6) begin
        in0_if.data = 64'hC000_0000 | (64'(e) << 8);
        in1_if.data = 64'hD000_0001 | (64'(e) << 8);
      end else begin
        in0_if.valid = 1'b0;
        in1_if.valid = 1'b0;
      end
      if (e >= 2 && e <= 7) begin
        chk("par_out0_valid", 64'(out0_if.valid), 64'd1);
        chk("par_out0_data", out0_if.data, 64'hC000_0000 | (64'(e - 2) << 8));
        chk("par_out1_valid", 64'(out1_if.valid), 64'd1);
        chk("par_out1_data", out1_if.data, 64'hD000_0001 | (64'(e - 2) << 8));
      end else if (e == 8) begin
        chk("par_out0_end", 64'(out0_if.valid), 64'd0);
        chk("par_out1_end", 64'(out1_if.valid), 64'd0);
      end
    end

    // Out-of-range level routes everything to out0
    do_reset(2'd3);
    in0_if.data  = 64'hE7;
    in0_if.valid = 1'b1;
    step();
    in0_if.valid = 1'b0;
    step();
    chk("lvl_ill_out0_valid", 64'(out0_if.valid), 64'd1);
    chk("lvl_ill_out0_data", out0_if.data, 64'hE7);
    chk("lvl_ill_out1_valid", 64'(out1_if.valid), 64'd0);

    // Mid-stream asynchronous reset with 5 flits buffered
    do_reset(2'd0);
    out0_if.ready = 1'b0;
    k0 = 0;
    in0_if.data  = 64'hA0;
    in0_if.valid = 1'b1;
    for (int c = 0; c < 20 && k0 < 6; c++) begin
      a0 = in0_if.valid && in0_if.ready;
      step();
      if (a0) begin
        k0++;
        in0_if.data = 64'hA0 | (64'(k0) << 8);
      end
    end
    in0_if.valid = 1'b0;
    chk("mid_cnt0_before", 64'(cnt0), 64'd5);
    chk("mid_out0_before", 64'(out0_if.valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_cnt0_async", 64'(cnt0), 64'd0);
    chk("mid_out0_valid_async", 64'(out0_if.valid), 64'd0);
    chk("mid_out0_data_async", out0_if.data, 64'd0);
    chk("mid_ready0_async", 64'(in0_if.ready), 64'd1);
    #2;
    rst = 1'b1;
    out0_if.ready = 1'b1;
    in0_if.data  = 64'hF0;
    in0_if.valid = 1'b1;
    step();
    in0_if.valid = 1'b0;
    chk("mid_post_early", 64'(out0_if.valid), 64'd0);
    chk("mid_post_cnt0", 64'(cnt0), 64'd1);
    step();
    chk("mid_post_valid", 64'(out0_if.valid), 64'd1);
    chk("mid_post_data", out0_if.data, 64'hF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
